seg_display_scan: RTL

Consumes the 32-bit latched LED value and drives an 8-digit multiplexed seven-segment display. Each digit shows one hex nibble. A prescaler sets the digit refresh rate. The value is snapshotted once per scan frame, so a digit never mixes old and new data mid-frame. The block sits directly downstream of the LED latch register, and its outputs go straight to board pins.

---
 rtl/seg_display_scan.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seg_display_scan.sv
// seg_display_scan: scans an 8-digit multiplexed seven-segment display.
// Each digit shows one hex nibble of a snapshot of data_in. The snapshot is
// taken once per scan frame, so a frame never mixes old and new data.
module seg_display_scan #(
  parameter int CLK_DIV        = 100000,
  parameter int ACTIVE_LOW_AN  = 1,
  parameter int ACTIVE_LOW_SEG = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        en,
  input  logic        lz_blank,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        digit_tick
);

  localparam int            PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(CLK_DIV - 1);
  localparam logic [7:0]    AN_OFF  = (ACTIVE_LOW_AN != 0) ? 8'hFF : 8'h00;
  localparam logic [6:0]    SEG_OFF = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
  localparam logic          DP_OFF  = (ACTIVE_LOW_SEG != 0);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [31:0]   r_snap;
  logic          r_digitTick;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;

  logic          w_tick;
  logic [3:0]    w_nibble;
  logic [6:0]    w_segHigh;
  logic [2:0]    w_lead;
  logic [7:0]    w_oneHot;
  logic [7:0]    w_anNext;
  logic [6:0]    w_segNext;

  assign w_tick     = (r_presc == P_LAST);
  assign w_nibble   = r_snap[{r_idx, 2'b00} +: 4];
  assign w_oneHot   = 8'b0000_0001 << r_idx;
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = DP_OFF;
  assign digit_tick = r_digitTick;

  // Prescaler, scan index and frame snapshot; the snapshot is taken on the
  // tick that wraps the index back to digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_snap      <= '0;
      r_digitTick <= 1'b0;
    end else begin
      r_digitTick <= w_tick;
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= r_idx + 3'd1;
        if (r_idx == 3'd7) begin
          r_snap <= data_in;
        end
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Position of the most significant nonzero nibble; digit 0 when all zero.
  always_comb begin
    w_lead = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (r_snap[4*k +: 4] != 4'h0) begin
        w_lead = 3'(k);
      end
    end
  end

  // Hex to active-high segment pattern {g,f,e,d,c,b,a}.
  always_comb begin
    w_segHigh = 7'h00;
    case (w_nibble)
      4'h0: w_segHigh = 7'h3F;
      4'h1: w_segHigh = 7'h06;
      4'h2: w_segHigh = 7'h5B;
      4'h3: w_segHigh = 7'h4F;
      4'h4: w_segHigh = 7'h66;
      4'h5: w_segHigh = 7'h6D;
      4'h6: w_segHigh = 7'h7D;
      4'h7: w_segHigh = 7'h07;
      4'h8: w_segHigh = 7'h7F;
      4'h9: w_segHigh = 7'h6F;
      4'hA: w_segHigh = 7'h77;
      4'hB: w_segHigh = 7'h7C;
      4'hC: w_segHigh = 7'h39;
      4'hD: w_segHigh = 7'h5E;
      4'hE: w_segHigh = 7'h79;
      4'hF: w_segHigh = 7'h71;
      default: w_segHigh = 7'h00;
    endcase
  end

  // Next pin values: the anode is dark when disabled or when the slot is a
  // blanked leading zero; digit 0 can never exceed w_lead so it always lights.
  always_comb begin
    w_anNext  = (ACTIVE_LOW_AN != 0) ? ~w_oneHot : w_oneHot;
    w_segNext = (ACTIVE_LOW_SEG != 0) ? ~w_segHigh : w_segHigh;
    if (!en || (lz_blank && (r_idx > w_lead))) begin
      w_anNext = AN_OFF;
    end
  end

  // Pin registers, one cycle behind the scan index so pins are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
    end else begin
      r_an  <= w_anNext;
      r_seg <= w_segNext;
    end
  end

endmodule
